// File: rtl/eth_crc_pkg.sv
// Shared constants, FSM state type and single-bit update for the Ethernet CRC-32 engine.
package eth_crc_pkg;

   localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
   localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
   localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      FCS_OUT
   } state_t;

   function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic b);
      return (crc >> 1) ^ (((b ^ crc[0]) != 1'b0) ? CRC_POLY : '0);
   endfunction

endpackage

// File: rtl/eth_crc32_step_n.sv
// Combinational CRC-32 update over one DATA_W-bit beat, unrolled bit-serially.
module eth_crc32_step_n
   import eth_crc_pkg::*;
#(
   parameter int unsigned DATA_W    = 2,
   parameter bit          BIT_ORDER = 1'b1
) (
   input  logic [31:0]       crc_in,
   input  logic [DATA_W-1:0] data,
   output logic [31:0]       crc_out
);

   logic [31:0] c;

   always_comb begin
      c = crc_in;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         c = crc32_step(c, BIT_ORDER ? data[DATA_W-1-i] : data[i]);
      end
      crc_out = c;
   end

endmodule

// File: rtl/eth_crc32_engine.sv
// Ethernet CRC-32 engine over DATA_W-bit beats: residue check of received frames,
// or generation of the FCS shifted out in DATA_W-bit beats with backpressure.
module eth_crc32_engine
   import eth_crc_pkg::*;
#(
   parameter int unsigned DATA_W    = 2,
   parameter bit          BIT_ORDER = 1'b1
) (
   input  logic              eth_clk,
   input  logic              rst_in,
   input  logic              in_valid,
   input  logic              in_sof,
   input  logic              in_eof,
   input  logic [DATA_W-1:0] in_data,
   input  logic              gen_mode,
   output logic              busy,
   output logic [31:0]       crc_out,
   output logic              crc_done,
   output logic              crc_ok,
   output logic              fcs_valid,
   output logic [DATA_W-1:0] fcs_data,
   output logic              fcs_last,
   input  logic              fcs_ready
);

   if (!(DATA_W == 1 || DATA_W == 2 || DATA_W == 4 || DATA_W == 8)) begin : g_bad_width
      $error("eth_crc32_engine: DATA_W must be 1, 2, 4 or 8");
   end

   localparam int unsigned BEATS = 32 / DATA_W;
   localparam int unsigned CNT_W = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   state_t            state;
   logic              mode;
   logic [31:0]       crc_reg;
   logic [31:0]       crc_seed;
   logic [31:0]       crc_next;
   logic [31:0]       fcs_sr;
   logic [CNT_W-1:0]  fcs_cnt;
   logic              accept;
   logic              frame_gen;

   // A sof beat always reseeds, which also covers the abort-in-ACCUM case.
   assign accept    = in_valid && ((state == ACCUM) || (state == IDLE && in_sof));
   assign crc_seed  = in_sof ? CRC_INIT : crc_reg;
   assign frame_gen = in_sof ? gen_mode : mode;

   eth_crc32_step_n #(
      .DATA_W    (DATA_W),
      .BIT_ORDER (BIT_ORDER)
   ) u_step (
      .crc_in  (crc_seed),
      .data    (in_data),
      .crc_out (crc_next)
   );

   always_ff @(posedge eth_clk) begin
      if (rst_in) begin
         state    <= IDLE;
         mode     <= 1'b0;
         crc_reg  <= CRC_INIT;
         crc_done <= 1'b0;
         crc_ok   <= 1'b0;
         fcs_sr   <= '0;
         fcs_cnt  <= '0;
      end else begin
         crc_done <= 1'b0;
         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  crc_reg <= crc_next;
                  mode    <= frame_gen;
                  if (in_sof) crc_ok <= 1'b0;
                  if (in_eof) begin
                     crc_done <= 1'b1;
                     if (frame_gen) begin
                        crc_ok  <= 1'b0;
                        fcs_sr  <= ~crc_next;
                        fcs_cnt <= '0;
                        state   <= FCS_OUT;
                     end else begin
                        crc_ok <= (crc_next == CRC_RESIDUE);
                        state  <= IDLE;
                     end
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            FCS_OUT: begin
               if (fcs_ready) begin
                  fcs_sr <= fcs_sr >> DATA_W;
                  if (fcs_cnt == LAST) begin
                     fcs_cnt <= '0;
                     state   <= IDLE;
                  end else begin
                     fcs_cnt <= fcs_cnt + CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign crc_out   = ~crc_reg;
   assign fcs_valid = (state == FCS_OUT);
   assign fcs_last  = fcs_valid && (fcs_cnt == LAST);

   // FCS leaves LSB first; with BIT_ORDER=1 the first serial bit sits in the MSB lane.
   always_comb begin
      fcs_data = '0;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         fcs_data[i] = BIT_ORDER ? fcs_sr[DATA_W-1-i] : fcs_sr[i];
      end
   end

endmodule

// File: tb/tb_eth_crc32_engine.sv
// Scoreboard bench for eth_crc32_engine: byte-wide LSB-first instance and dibit legacy-order instance.
module tb_eth_crc32_engine;

   logic eth_clk = 1'b0;
   always #5 eth_clk = ~eth_clk;

   logic rst_in = 1'b1;

   logic        v8 = 0, sof8 = 0, eof8 = 0, gm8 = 0, rdy8 = 0;
   logic [7:0]  d8 = '0;
   logic        busy8, done8, ok8, fv8, fl8;
   logic [31:0] crc8;
   logic [7:0]  fd8;

   logic        v2 = 0, sof2 = 0, eof2 = 0, gm2 = 0, rdy2 = 0;
   logic [1:0]  d2 = '0;
   logic        busy2, done2, ok2, fv2, fl2;
   logic [31:0] crc2;
   logic [1:0]  fd2;

   eth_crc32_engine #(.DATA_W(8), .BIT_ORDER(1'b0)) u8 (
      .eth_clk(eth_clk), .rst_in(rst_in), .in_valid(v8), .in_sof(sof8), .in_eof(eof8),
      .in_data(d8), .gen_mode(gm8), .busy(busy8), .crc_out(crc8), .crc_done(done8),
      .crc_ok(ok8), .fcs_valid(fv8), .fcs_data(fd8), .fcs_last(fl8), .fcs_ready(rdy8));

   eth_crc32_engine #(.DATA_W(2), .BIT_ORDER(1'b1)) u2 (
      .eth_clk(eth_clk), .rst_in(rst_in), .in_valid(v2), .in_sof(sof2), .in_eof(eof2),
      .in_data(d2), .gen_mode(gm2), .busy(busy2), .crc_out(crc2), .crc_done(done2),
      .crc_ok(ok2), .fcs_valid(fv2), .fcs_data(fd2), .fcs_last(fl2), .fcs_ready(rdy2));

   int checks = 0;
   int errors = 0;

   logic       ok8_q[$];
   logic [8:0] fcs8_q[$];
   logic       ok2_q[$];
   logic [2:0] fcs2_q[$];

   logic [7:0] msg[9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
   logic [7:0] fcs[4] = '{8'h26, 8'h39, 8'hF4, 8'hCB};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_bit(input logic [31:0] c, input logic b);
      return (c >> 1) ^ (((b ^ c[0]) != 1'b0) ? 32'hEDB88320 : 32'h0);
   endfunction

   // Monitor: pops expectations whenever the DUTs present a result or an FCS handshake.
   logic       hold8_v = 0, hold2_v = 0;
   logic [8:0] hold8 = '0;
   logic [2:0] hold2 = '0;

   always @(negedge eth_clk) begin
      if (done8) begin
         if (ok8_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done8_unexpected: got crc_done=1 required no pulse");
         end else chk("crc_ok8", 32'(ok8), 32'(ok8_q.pop_front()));
      end
      if (fv8) begin
         if (hold8_v) chk("fcs8_stable", 32'({fl8, fd8}), 32'(hold8));
         if (rdy8) begin
            if (fcs8_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL fcs8_unexpected: got beat %h required none", {fl8, fd8});
            end else chk("fcs8_beat", 32'({fl8, fd8}), 32'(fcs8_q.pop_front()));
         end
         hold8_v = !rdy8;
         hold8   = {fl8, fd8};
      end else hold8_v = 1'b0;

      if (done2) begin
         if (ok2_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done2_unexpected: got crc_done=1 required no pulse");
         end else chk("crc_ok2", 32'(ok2), 32'(ok2_q.pop_front()));
      end
      if (fv2) begin
         if (hold2_v) chk("fcs2_stable", 32'({fl2, fd2}), 32'(hold2));
         if (rdy2) begin
            if (fcs2_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL fcs2_unexpected: got beat %h required none", {fl2, fd2});
            end else chk("fcs2_beat", 32'({fl2, fd2}), 32'(fcs2_q.pop_front()));
         end
         hold2_v = !rdy2;
         hold2   = {fl2, fd2};
      end else hold2_v = 1'b0;
   end

   task automatic beat8(input logic s, input logic e, input logic [7:0] d);
      @(posedge eth_clk); #2;
      v8 = 1'b1; sof8 = s; eof8 = e; d8 = d;
   endtask

   task automatic idle8();
      @(posedge eth_clk); #2;
      v8 = 1'b0; sof8 = 1'b0; eof8 = 1'b0;
   endtask

   task automatic beat2(input logic s, input logic e, input logic [1:0] d);
      @(posedge eth_clk); #2;
      v2 = 1'b1; sof2 = s; eof2 = e; d2 = d;
   endtask

   task automatic idle2();
      @(posedge eth_clk); #2;
      v2 = 1'b0; sof2 = 1'b0; eof2 = 1'b0;
   endtask

   task automatic frame8(input logic [7:0] flip);
      for (int i = 0; i < 9; i++) beat8(i == 0, 1'b0, msg[i] ^ ((i == 4) ? flip : 8'h00));
      for (int k = 0; k < 4; k++) beat8(1'b0, k == 3, fcs[k]);
      idle8();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  rb[64];
      logic [31:0] m;
      logic [31:0] s;
      logic [1:0]  dib;
      logic [1:0]  cap[$];
      logic        rp[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int          n;

      // Reset state
      repeat (3) @(posedge eth_clk);
      #2 rst_in = 1'b0;
      @(negedge eth_clk);
      chk("rst_crc8", crc8, 32'h0);
      chk("rst_busy8", 32'(busy8), 32'h0);
      chk("rst_ok8", 32'(ok8), 32'h0);
      chk("rst_fv8", 32'({fv8, fl8, fd8}), 32'h0);
      chk("rst_crc2", crc2, 32'h0);
      chk("rst_busy2", 32'({busy2, fv2, ok2}), 32'h0);

      // Check mode: "123456789" then its FCS
      gm8 = 1'b0;
      for (int i = 0; i < 9; i++) beat8(i == 0, 1'b0, msg[i]);
      idle8();
      @(negedge eth_clk);
      chk("crc_123456789", crc8, 32'hCBF43926);
      chk("busy_accum", 32'(busy8), 32'h1);
      ok8_q.push_back(1'b1);
      for (int k = 0; k < 4; k++) beat8(1'b0, k == 3, fcs[k]);
      idle8();
      @(negedge eth_clk);
      chk("busy_after_check", 32'(busy8), 32'h0);
      repeat (2) @(posedge eth_clk);

      // Corrupted payload bit
      ok8_q.push_back(1'b0);
      frame8(8'h01);
      repeat (2) @(posedge eth_clk);

      // Generate mode with backpressure
      gm8 = 1'b1; rdy8 = 1'b0;
      ok8_q.push_back(1'b0);
      for (int k = 0; k < 4; k++) fcs8_q.push_back({k == 3, fcs[k]});
      for (int i = 0; i < 9; i++) beat8(i == 0, i == 8, msg[i]);
      for (int k = 0; k < 6; k++) begin
         @(posedge eth_clk); #2;
         v8 = 1'b0; sof8 = 1'b0; eof8 = 1'b0; rdy8 = rp[k];
         if (k == 0) begin
            @(negedge eth_clk);
            chk("busy_fcs", 32'(busy8), 32'h1);
            chk("crc_gen", crc8, 32'hCBF43926);
         end
      end
      @(posedge eth_clk); #2 rdy8 = 1'b0;
      @(negedge eth_clk);
      chk("busy_after_fcs", 32'({busy8, fv8}), 32'h0);
      chk("crc_hold_idle", crc8, 32'hCBF43926);

      // Abort mid-frame, then a full good frame
      gm8 = 1'b0;
      beat8(1'b1, 1'b0, 8'h31); beat8(1'b0, 1'b0, 8'h32); beat8(1'b0, 1'b0, 8'h33);
      ok8_q.push_back(1'b1);
      frame8(8'h00);
      repeat (2) @(posedge eth_clk);

      // Single-beat frame 0x00
      ok8_q.push_back(1'b0);
      beat8(1'b1, 1'b1, 8'h00);
      idle8();
      @(negedge eth_clk);
      chk("crc_single_00", crc8, 32'hD202EF8D);
      chk("busy_single", 32'(busy8), 32'h0);
      repeat (2) @(posedge eth_clk);

      // Reset during FCS beat 2, then a good check frame
      gm8 = 1'b1; rdy8 = 1'b1;
      ok8_q.push_back(1'b0);
      fcs8_q.push_back({1'b0, 8'h26});
      fcs8_q.push_back({1'b0, 8'h39});
      for (int i = 0; i < 9; i++) beat8(i == 0, i == 8, msg[i]);
      idle8();
      @(posedge eth_clk); #2;
      @(posedge eth_clk); #2 rst_in = 1'b1; rdy8 = 1'b0;
      @(posedge eth_clk); #2 rst_in = 1'b0;
      @(negedge eth_clk);
      chk("rst_mid_fcs_fv", 32'({fv8, fl8}), 32'h0);
      chk("rst_mid_fcs_busy", 32'(busy8), 32'h0);
      chk("rst_mid_fcs_crc", crc8, 32'h0);
      gm8 = 1'b0;
      ok8_q.push_back(1'b1);
      frame8(8'h00);
      repeat (2) @(posedge eth_clk);

      // Dibit legacy order: random 64-byte generate frame, tracked every cycle
      for (int i = 0; i < 64; i++) rb[i] = 8'($urandom_range(0, 255));
      gm2 = 1'b1; rdy2 = 1'b1;
      ok2_q.push_back(1'b0);
      m = 32'hFFFFFFFF;
      for (int i = 0; i < 256; i++) begin
         dib = rb[i/4][2*(i%4) +: 2];
         beat2(i == 0, i == 255, dib);
         if (i > 0) begin
            @(negedge eth_clk);
            chk("crc2_track", crc2, ~m);
         end
         m = ref_bit(ref_bit(m, dib[1]), dib[0]);
      end
      s = ~m;
      for (int k = 0; k < 16; k++) fcs2_q.push_back({k == 15, s[2*k], s[2*k+1]});
      idle2();
      @(negedge eth_clk);
      chk("crc2_final", crc2, ~m);
      chk("busy2_fcs", 32'(busy2), 32'h1);
      n = 0;
      for (int t = 0; t < 40 && n < 16; t++) begin
         if (fv2 && rdy2) begin
            cap.push_back(fd2);
            n++;
         end
         @(negedge eth_clk);
      end
      chk("fcs2_count", 32'(n), 32'd16);

      // Loopback the captured FCS into a check-mode frame
      gm2 = 1'b0;
      ok2_q.push_back(1'b1);
      for (int i = 0; i < 256; i++) beat2(i == 0, 1'b0, rb[i/4][2*(i%4) +: 2]);
      for (int k = 0; k < cap.size(); k++) beat2(1'b0, k == cap.size() - 1, cap[k]);
      idle2();
      repeat (5) @(posedge eth_clk);
      @(negedge eth_clk);

      chk("ok8_q_drained", 32'(ok8_q.size()), 32'h0);
      chk("fcs8_q_drained", 32'(fcs8_q.size()), 32'h0);
      chk("ok2_q_drained", 32'(ok2_q.size()), 32'h0);
      chk("fcs2_q_drained", 32'(fcs2_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
